piso_mux_n: RTL and testbench

//   Parallel-in serial-out stage wrapped around the mux_n selector tree.
//   - Accepts a 2**N-bit word on a valid/ready handshake.
//   - Steps an internal bit index through all 2**N positions, driving the mux_n select input.
//   - Emits one bit per accepted output beat on a second valid/ready handshake.
//   It is the control stage that feeds mux_n its select and consumes its output.

---
 rtl/mux_n_pkg.sv | 27 ++
 rtl/mux_n.sv | 40 ++++
 rtl/piso_mux_n.sv | 116 +++++++++++
 tb/tb_piso_mux_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pkg.sv
// Shared types and helpers for the mux_n selector tree and its PISO control stage.
package mux_n_pkg;

    // Largest supported log2 word width.
    localparam int MAX_N = 8;

    // Control states of the parallel-in serial-out stage.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Reverse the low n bits of v. Bits at and above n come back as zero.
    // The tree decodes its select LSB-at-root, so a bit position must be
    // mirrored before it becomes a select value.
    function automatic logic [7:0] bit_reverse(logic [7:0] v, int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                r[i] = v[n - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n.sv
// Binary 2**N:1 selector tree. The first reduction level (adjacent bit pairs)
// is steered by sel[N-1], and the final level (top-level halves) by sel[0].
module mux_n
    import mux_n_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [(1 << N) - 1:0]   data_in,
    input  logic [(N > 0 ? N : 1) - 1:0] sel,
    output logic                    data_out
);

    localparam int W = 1 << N;

    if (N == 0) begin : g_single
        // A one-bit word needs no selection; the select input carries nothing.
        logic unused_sel;
        assign unused_sel = ^sel;
        assign data_out   = data_in[0];
    end else begin : g_tree
        for (genvar j = 0; j < N; j++) begin : g_lvl
            localparam int OW = W >> (j + 1);
            logic [2*OW-1:0] src;
            logic [OW-1:0]   v;

            if (j == 0) begin : g_leaf
                assign src = data_in;
            end else begin : g_node
                assign src = g_lvl[j-1].v;
            end

            // Each level halves the candidates using one select bit, deepest select bit first.
            for (genvar i = 0; i < OW; i++) begin : g_pair
                assign v[i] = sel[N-1-j] ? src[2*i+1] : src[2*i];
            end
        end
        assign data_out = g_lvl[N-1].v[0];
    end

endmodule

// File: rtl/piso_mux_n.sv
// Parallel-in serial-out control stage around the mux_n selector tree.
// Captures a 2**N-bit word on an input handshake and emits it one bit per
// output handshake, with no bubble between back-to-back words.
module piso_mux_n
    import mux_n_pkg::*;
#(
    parameter int N         = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(1 << N) - 1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_bit,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_last,
    output logic                  busy
);

    localparam int W  = 1 << N;
    localparam int IW = (N > 0) ? N : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    piso_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  word_q, word_d;

    logic [IW-1:0] pos;
    logic [IW-1:0] sel;
    logic          tree_bit;
    logic          is_last;
    logic          accept;
    logic          beat;

    // Map the beat index to a word bit position, then mirror it for the tree's select order.
    always_comb begin
        pos     = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
        sel     = IW'(bit_reverse(8'(pos), N));
        is_last = (idx_q == LAST_IDX);
    end

    mux_n #(.N(N)) u_sel (
        .data_in  (word_q),
        .sel      (sel),
        .data_out (tree_bit)
    );

    // Handshake outputs; reset forces every output low regardless of the stored state.
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        ser_bit   = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end else begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_bit   = tree_bit;
                ser_last  = is_last;
                in_ready  = is_last && ser_ready;
            end
        end
        accept = in_valid && in_ready;
        beat   = ser_valid && ser_ready;
    end

    // Next state: capture on accept, advance on each beat, reload on a last-beat accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (!is_last) begin
                        idx_d = idx_q + IW'(1);
                    end else if (accept) begin
                        word_d = in_data;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index and word registers with synchronous reset that drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_piso_mux_n.sv
// Self-checking bench for piso_mux_n: LSB-first N=3 with a scoreboard,
// plus MSB-first N=3 and single-bit N=0 instances.
module tb_piso_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0] in_data;
    logic       in_valid, in_ready, ser_bit, ser_valid, ser_ready, ser_last, busy;

    logic [7:0] m_in_data;
    logic       m_in_valid, m_in_ready, m_ser_bit, m_ser_valid, m_ser_ready, m_ser_last, m_busy;

    logic       z_in_data;
    logic       z_in_valid, z_in_ready, z_ser_bit, z_ser_valid, z_ser_ready, z_ser_last, z_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] exp_q[$];
    logic       stall_seen = 1'b0;
    logic       held_bit, held_last;

    piso_mux_n #(.N(3), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy)
    );

    piso_mux_n #(.N(3), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .ser_bit(m_ser_bit), .ser_valid(m_ser_valid), .ser_ready(m_ser_ready), .ser_last(m_ser_last), .busy(m_busy)
    );

    piso_mux_n #(.N(0), .MSB_FIRST(0)) dut_n0 (
        .clk(clk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .ser_bit(z_ser_bit), .ser_valid(z_ser_valid), .ser_ready(z_ser_ready), .ser_last(z_ser_last), .busy(z_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Expected LSB-first bit stream of one word, last flag on the eighth bit.
    task automatic pushWord(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({w[i], (i == 7)});
        end
    endtask

    // Present a word and wait for it to be accepted; returns just after the accepting edge with in_valid still high.
    task automatic applyStimulus(input logic [7:0] w);
        logic accepted;
        accepted = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                pushWord(w);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops one expected bit per completed beat and checks stall stability.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && ser_valid) begin
                checkOutput("stall_bit", ser_bit, held_bit);
                checkOutput("stall_last", ser_last, held_last);
            end
            stall_seen = 1'b0;
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", ser_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ser_bit", ser_bit, e[1]);
                    checkOutput("ser_last", ser_last, e[0]);
                end
            end else if (ser_valid) begin
                stall_seen = 1'b1;
                held_bit   = ser_bit;
                held_last  = ser_last;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic pushed;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        ser_ready  = 1'b1;
        m_in_data  = '0;
        m_in_valid = 1'b0;
        m_ser_ready = 1'b1;
        z_in_data  = 1'b0;
        z_in_valid = 1'b0;
        z_ser_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_ser_valid", ser_valid, 0);
        checkOutput("rst_ser_last", ser_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ser_bit", ser_bit, 0);
        checkOutput("rst_m_in_ready", m_in_ready, 0);
        checkOutput("rst_z_ser_valid", z_ser_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 1);
        checkOutput("idle_busy", busy, 0);
        @(posedge clk);
        #1;

        // Single word, no backpressure
        applyStimulus(8'b1011_0010);
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checkOutput("t1_valid", ser_valid, 1);
            checkOutput("t1_busy", busy, 1);
            checkOutput("t1_last", ser_last, (c == 8));
            checkOutput("t1_in_ready", in_ready, (c == 8));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("t1_done_valid", ser_valid, 0);
        checkOutput("t1_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Backpressure: ready alternates 1,0
        applyStimulus(8'b1011_0010);
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ser_ready = (c % 2 == 0);
            @(negedge clk);
            if (c < 15) checkOutput("bp_valid", ser_valid, 1);
            @(posedge clk);
            #1;
        end
        ser_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_drained", exp_q.size(), 0);
        checkOutput("bp_done_valid", ser_valid, 0);
        @(posedge clk);
        #1;

        // Back-to-back words with in_valid held
        applyStimulus(8'hA5);
        in_data = 8'h3C;
        pushed  = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checkOutput("b2b_valid", ser_valid, 1);
            checkOutput("b2b_last", ser_last, (c == 8 || c == 16));
            if (in_ready && in_valid && !pushed) begin
                pushWord(8'h3C);
                pushed = 1'b1;
                checkOutput("b2b_accept_cycle", c, 8);
            end
            @(posedge clk);
            #1;
            if (pushed) in_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("b2b_drained", exp_q.size(), 0);
        checkOutput("b2b_done_valid", ser_valid, 0);
        @(posedge clk);
        #1;

        // Reset mid-word at idx=3, with in_valid asserted during reset
        applyStimulus(8'b1011_0010);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("mid_rst_in_ready", in_ready, 0);
            checkOutput("mid_rst_ser_valid", ser_valid, 0);
            checkOutput("mid_rst_ser_last", ser_last, 0);
            checkOutput("mid_rst_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            checkOutput("post_rst_no_stale", ser_valid, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // MSB-first: 8'h01 gives seven zeros then a final one
        m_in_data  = 8'h01;
        m_in_valid = 1'b1;
        @(negedge clk);
        checkOutput("msb_in_ready", m_in_ready, 1);
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checkOutput("msb_valid", m_ser_valid, 1);
            checkOutput("msb_bit", m_ser_bit, (c == 8));
            checkOutput("msb_last", m_ser_last, (c == 8));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("msb_done_valid", m_ser_valid, 0);
        @(posedge clk);
        #1;

        // N=0: each word is a single last beat, back-to-back accepted
        z_in_data  = 1'b1;
        z_in_valid = 1'b1;
        @(negedge clk);
        checkOutput("n0_idle_ready", z_in_ready, 1);
        @(posedge clk);
        #1;
        z_in_data = 1'b0;
        @(negedge clk);
        checkOutput("n0_valid1", z_ser_valid, 1);
        checkOutput("n0_bit1", z_ser_bit, 1);
        checkOutput("n0_last1", z_ser_last, 1);
        checkOutput("n0_in_ready1", z_in_ready, 1);
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;
        @(negedge clk);
        checkOutput("n0_valid2", z_ser_valid, 1);
        checkOutput("n0_bit2", z_ser_bit, 0);
        checkOutput("n0_last2", z_ser_last, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("n0_done_valid", z_ser_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
